exc_commit: RTL
===============

EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have parameter STAT_W, default 32, width of statistics counters.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ws_valid in 1, ws_ready out 1: writeback-stage instruction handshake; an instruction commits when both are high.
REQ-005 SHALL have ports ws_pc in 32, ws_vaddr in 32: instruction PC and memory address.
REQ-006 SHALL have port ws_exc in 5: bit0 ADEF, bit1 INE, bit2 SYS, bit3 BRK, bit4 ALE.
REQ-007 SHALL have port ws_ertn in 1: the instruction is ERTN.
REQ-008 SHALL have ports ws_csr_op in 2 (00 none, 01 rd, 10 wr, 11 xchg), ws_csr_num in 14, ws_csr_wdata in 32, ws_csr_mask in 32.
REQ-009 SHALL have inputs has_int 1, csr_rvalue 32, ex_entry 32, ex_epc 32, all from the CSR file.
REQ-010 SHALL have outputs csr_we 1, csr_re 1, csr_num 14, csr_wmask 32, csr_wvalue 32, wb_ex 1, ertn_flush 1, wb_ecode 6, wb_esubcode 9, wb_pc 32, wb_vaddr 32, all to the CSR file.
REQ-011 SHALL have output rf_csr_data 32: CSR read data returned to the register-file write port.
REQ-012 SHALL have outputs pipe_flush 1, redirect_valid 1, redirect_pc 32, and input redirect_ready 1: fetch redirect handshake.

Function
REQ-013 SHALL implement FSM IDLE/REDIR; ws_ready=1 only in IDLE.
REQ-014 In IDLE on commit, event SHALL be: exception if has_int or ws_exc!=0; else ertn if ws_ertn; else normal.
REQ-015 Exception priority SHALL be INT(0x0) > ADEF(0x8, sub 0) > INE(0xD) > SYS(0xB) > BRK(0xC) > ALE(0x9); esubcode 0 for all.
REQ-016 On exception commit: wb_ex=1 combinationally that cycle; wb_pc=ws_pc; wb_vaddr=ws_vaddr; redirect_pc<=ex_entry; next state REDIR.
REQ-017 On ertn commit: ertn_flush=1 that cycle; redirect_pc<=ex_epc; next state REDIR.
REQ-018 On normal commit: rd drives csr_re=1; wr drives csr_we=1, wmask=all ones; xchg drives csr_we=1, wmask=ws_csr_mask; csr_re=1 for all three; wvalue=ws_csr_wdata; rf_csr_data=csr_rvalue same cycle (zero latency).
REQ-019 CSR writes SHALL be suppressed (csr_we=0) when the instruction raises an exception or is ERTN.
REQ-020 wb_ex, ertn_flush, csr_we, csr_re SHALL be 0 whenever not committing; csr_num SHALL follow ws_csr_num.
REQ-021 In REDIR: redirect_valid=1, pipe_flush=1, redirect_pc stable; return to IDLE on the cycle redirect_ready=1 (minimum one REDIR cycle).
REQ-022 has_int SHALL be ignored when ws_valid=0 and in REDIR.
REQ-023 redirect_pc SHALL hold its value in IDLE.

Reset
REQ-024 Reset SHALL force IDLE, redirect_pc=0, all outputs 0 except ws_ready=1; reset asserted in REDIR SHALL abandon the redirect.

Configuration
REQ-025 With EXC_STATS_EN defined, the block SHALL add outputs exc_count and ertn_count (STAT_W each), incremented on each exception/ertn commit, wrapping at all ones, reset to 0.
REQ-026 Without EXC_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-027 Ecode/esubcode constants, ws_csr_op encodings, and the FSM state type SHALL live in shared package exc_pkg.
REQ-028 Priority selection SHALL be a sub-module exc_prio (ws_exc, has_int -> valid, ecode, esubcode).

Verification
REQ-029 csr_op=10, num=0x30, wdata=0x1234 -> csr_we=1, wmask=0xFFFFFFFF, wvalue=0x1234, no flush.
REQ-030 ws_exc=5'b10100, pc=0x1c000100, ex_entry=0x1c008000 -> wb_ex=1, ecode=0xB, wb_pc=0x1c000100, redirect_pc=0x1c008000 next cycle.
REQ-031 has_int=1 with csr_op=10 -> ecode=0x0, csr_we=0.
REQ-032 ws_ertn=1, ex_epc=0x1c000104, redirect_ready held low 3 cycles -> ertn_flush one cycle, redirect_valid=1 and ws_ready=0 for 4 cycles.
REQ-033 Reset asserted mid-REDIR -> immediate IDLE, redirect_valid=0, ws_ready=1.
REQ-034 With EXC_STATS_EN, 3 exceptions + 1 ertn -> exc_count=3, ertn_count=1.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/commit slice: ecodes, CSR op encodings, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package exc_pkg;

   // Exception codes reported to the CSR file
   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   // Every exception this block raises uses subcode 0
   localparam logic [8:0] ESUBCODE_NONE = 9'h000;

   // Bit positions inside ws_exc
   localparam int EXC_ADEF_BIT = 0;
   localparam int EXC_INE_BIT  = 1;
   localparam int EXC_SYS_BIT  = 2;
   localparam int EXC_BRK_BIT  = 3;
   localparam int EXC_ALE_BIT  = 4;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RD   = 2'b01,
      CSR_WR   = 2'b10,
      CSR_XCHG = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_REDIR = 1'b1
   } state_e;

endpackage

// File: rtl/exc_prio.sv
// Fixed-priority exception selector: INT > ADEF > INE > SYS > BRK > ALE.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module exc_prio
   import exc_pkg::*;
(
   input  logic [4:0] ws_exc,
   input  logic       has_int,
   output logic       valid,
   output logic [5:0] ecode,
   output logic [8:0] esubcode
);

   // Highest-priority pending cause wins
   always_comb begin
      valid    = has_int | (|ws_exc);
      ecode    = ECODE_INT;
      esubcode = ESUBCODE_NONE;
      if (has_int)                   ecode = ECODE_INT;
      else if (ws_exc[EXC_ADEF_BIT]) ecode = ECODE_ADEF;
      else if (ws_exc[EXC_INE_BIT])  ecode = ECODE_INE;
      else if (ws_exc[EXC_SYS_BIT])  ecode = ECODE_SYS;
      else if (ws_exc[EXC_BRK_BIT])  ecode = ECODE_BRK;
      else if (ws_exc[EXC_ALE_BIT])  ecode = ECODE_ALE;
   end

endmodule

// File: rtl/exc_commit.sv
// Writeback commit: classifies exception/ertn/normal, drives CSR access, redirects fetch.
// Latency: CSR and exception signals same cycle as commit; redirect_pc registered, valid from next cycle.
// Backpressure: ws_ready low while a redirect waits for redirect_ready. Optional EXC_STATS_EN adds counters.
module exc_commit
   import exc_pkg::*;
#(
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ws_valid,
   output logic              ws_ready,
   input  logic [31:0]       ws_pc,
   input  logic [31:0]       ws_vaddr,
   input  logic [4:0]        ws_exc,
   input  logic              ws_ertn,
   input  logic [1:0]        ws_csr_op,
   input  logic [13:0]       ws_csr_num,
   input  logic [31:0]       ws_csr_wdata,
   input  logic [31:0]       ws_csr_mask,
   input  logic              has_int,
   input  logic [31:0]       csr_rvalue,
   input  logic [31:0]       ex_entry,
   input  logic [31:0]       ex_epc,
   output logic              csr_we,
   output logic              csr_re,
   output logic [13:0]       csr_num,
   output logic [31:0]       csr_wmask,
   output logic [31:0]       csr_wvalue,
   output logic              wb_ex,
   output logic              ertn_flush,
   output logic [5:0]        wb_ecode,
   output logic [8:0]        wb_esubcode,
   output logic [31:0]       wb_pc,
   output logic [31:0]       wb_vaddr,
   output logic [31:0]       rf_csr_data,
   output logic              pipe_flush,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
`ifdef EXC_STATS_EN
   output logic [STAT_W-1:0] exc_count,
   output logic [STAT_W-1:0] ertn_count,
`endif
   input  logic              redirect_ready
);

   state_e      state_q, state_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        redir_vld_q, redir_vld_d;
   logic        ws_ready_q, ws_ready_d;

   logic        prio_vld;
   logic [5:0]  prio_ecode;
   logic [8:0]  prio_esubcode;
   logic        commit, exc_ev, ertn_ev, norm_ev;
   csr_op_e     op;

   exc_prio u_prio (
      .ws_exc   (ws_exc),
      .has_int  (has_int),
      .valid    (prio_vld),
      .ecode    (prio_ecode),
      .esubcode (prio_esubcode)
   );

   // Classify the committing instruction; has_int only matters on a real commit
   always_comb begin
      op      = csr_op_e'(ws_csr_op);
      commit  = ws_valid & ws_ready_q;
      exc_ev  = commit & prio_vld;
      ertn_ev = commit & ~prio_vld & ws_ertn;
      norm_ev = commit & ~prio_vld & ~ws_ertn;
   end

   // CSR file and register-file side effects of the current commit
   always_comb begin
      csr_re      = norm_ev & (op != CSR_NONE);
      csr_we      = norm_ev & ((op == CSR_WR) | (op == CSR_XCHG));
      csr_wmask   = '0;
      if (csr_we) csr_wmask = (op == CSR_XCHG) ? ws_csr_mask : 32'hFFFF_FFFF;
      csr_num     = ws_csr_num;
      csr_wvalue  = ws_csr_wdata;
      rf_csr_data = csr_rvalue;
      wb_ex       = exc_ev;
      ertn_flush  = ertn_ev;
      wb_ecode    = exc_ev ? prio_ecode : 6'h00;
      wb_esubcode = exc_ev ? prio_esubcode : 9'h000;
      wb_pc       = ws_pc;
      wb_vaddr    = ws_vaddr;
   end

   // Next-state logic: capture the redirect target on entry, hold it otherwise
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_ev) begin
               state_d       = ST_REDIR;
               redirect_pc_d = ex_entry;
            end else if (ertn_ev) begin
               state_d       = ST_REDIR;
               redirect_pc_d = ex_epc;
            end
         end
         ST_REDIR: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      redir_vld_d = (state_d == ST_REDIR);
      ws_ready_d  = (state_d == ST_IDLE);
   end

   // FSM state and its registered outputs; reset drops any pending redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= '0;
         redir_vld_q   <= 1'b0;
         ws_ready_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         redir_vld_q   <= redir_vld_d;
         ws_ready_q    <= ws_ready_d;
      end
   end

   assign ws_ready       = ws_ready_q;
   assign redirect_valid = redir_vld_q;
   assign pipe_flush     = redir_vld_q;
   assign redirect_pc    = redirect_pc_q;

`ifdef EXC_STATS_EN
   logic [STAT_W-1:0] exc_count_q, exc_count_d;
   logic [STAT_W-1:0] ertn_count_q, ertn_count_d;

   // Event counters wrap naturally at all ones
   always_comb begin
      exc_count_d  = exc_count_q + (exc_ev ? STAT_W'(1) : STAT_W'(0));
      ertn_count_d = ertn_count_q + (ertn_ev ? STAT_W'(1) : STAT_W'(0));
   end

   // Statistics registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_count_q  <= '0;
         ertn_count_q <= '0;
      end else begin
         exc_count_q  <= exc_count_d;
         ertn_count_q <= ertn_count_d;
      end
   end

   assign exc_count  = exc_count_q;
   assign ertn_count = ertn_count_q;
`endif

endmodule
